// File: rtl/matrix_pkg.sv
`default_nettype none
// ============================================================================
// Package  : matrix_pkg
// Desc     : Shared geometry, state encoding and address-width helper for the
//            matrix_ctrl MAC sequencer and its X operand buffer.
// Revision : 1.0 - initial release
// ============================================================================
package matrix_pkg;

    // Matrix geometry: X is K rows (MAC steps) by COLS lanes
    localparam int K       = 8;
    localparam int COLS    = 4;
    localparam int DATA_W  = 8;
    localparam int ACC_W   = 20;

    // Derived sizes for the X buffer and the loop counters
    localparam int X_DEPTH = K * COLS;
    localparam int IDX_W   = $clog2(X_DEPTH);
    localparam int K_W     = $clog2(K);
    localparam int COL_W   = $clog2(COLS);

    // Sequencer states
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        PRIME = 3'd2,
        MAC   = 3'd3,
        EMIT  = 3'd4
    } state_t;

    // Coefficient ROM address is {row, k}, so its width is row bits + k bits
    function automatic int coef_addr_w(input int n_rows);
        return $clog2(n_rows) + K_W;
    endfunction

endpackage
`default_nettype wire

// File: rtl/x_buffer.sv
`default_nettype none
// ============================================================================
// Module   : x_buffer
// Desc     : 32x8 register file holding the X matrix. One linear write port
//            used while loading, one combinational 4-wide read port that
//            returns a whole X row (all lanes of one MAC step).
// Revision : 1.0 - initial release
// ============================================================================
module x_buffer
    import matrix_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [IDX_W-1:0]       wr_idx,
    input  logic [DATA_W-1:0]      wr_data,
    input  logic [K_W-1:0]         rd_row,
    output logic [COLS*DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] r_mem [X_DEPTH];

    // Storage: cleared on reset, written one byte per accepted load beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < X_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (wr_en) begin
            r_mem[wr_idx] <= wr_data;
        end
    end

    // Row read: row-major layout means lane c of row k sits at {k, c}
    generate
        for (genvar c = 0; c < COLS; c++) begin : g_rd_col
            assign rd_data[c*DATA_W +: DATA_W] = r_mem[{rd_row, COL_W'(c)}];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/matrix_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : matrix_ctrl
// Desc     : Sequencer for the 4-lane MAC ALU. Buffers an 8x4 X matrix, then
//            for each coefficient row primes the ROM, runs 8 MAC steps,
//            captures the four lane sums and streams them out.
// Revision : 1.0 - initial release
// ============================================================================
module matrix_ctrl
    import matrix_pkg::*;
#(
    parameter int N_ROWS = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [DATA_W-1:0]              in_data,
    output logic [coef_addr_w(N_ROWS)-1:0] coef_addr,
    output logic                           alu_en,
    output logic [DATA_W-1:0]              x_col0,
    output logic [DATA_W-1:0]              x_col1,
    output logic [DATA_W-1:0]              x_col2,
    output logic [DATA_W-1:0]              x_col3,
    input  logic [ACC_W-1:0]               mu1,
    input  logic [ACC_W-1:0]               mu2,
    input  logic [ACC_W-1:0]               mu3,
    input  logic [ACC_W-1:0]               mu4,
    output logic                           res_valid,
    input  logic                           res_ready,
    output logic [ACC_W-1:0]               res_data,
    output logic                           busy,
    output logic                           done
);

    localparam int                  c_row_w    = $clog2(N_ROWS);
    localparam int                  c_addr_w   = coef_addr_w(N_ROWS);
    localparam logic [c_row_w-1:0]  c_last_row = c_row_w'(N_ROWS - 1);
    localparam logic [IDX_W-1:0]    c_last_idx = IDX_W'(X_DEPTH - 1);
    localparam logic [K_W-1:0]      c_last_k   = K_W'(K - 1);
    localparam logic [COL_W-1:0]    c_last_col = COL_W'(COLS - 1);

    // FSM state and loop counters
    state_t               r_state;
    state_t               w_state_nxt;
    logic [IDX_W-1:0]     r_idx;
    logic [IDX_W-1:0]     w_idx_nxt;
    logic [c_row_w-1:0]   r_row;
    logic [c_row_w-1:0]   w_row_nxt;
    logic [K_W-1:0]       r_k;
    logic [K_W-1:0]       w_k_nxt;
    logic [COL_W-1:0]     r_j;
    logic [COL_W-1:0]     w_j_nxt;
    logic                 w_done_nxt;

    // Handshakes and capture strobe
    logic                 w_load_hs;
    logic                 w_res_hs;
    logic                 w_capture;

    // Result path
    logic [ACC_W-1:0]     w_mu      [COLS];
    logic [ACC_W-1:0]     r_result  [COLS];
    logic [ACC_W-1:0]     w_res_src [COLS];

    // Registered outputs
    logic [COLS*DATA_W-1:0] w_x_row;
    logic [COLS*DATA_W-1:0] r_x_row;
    logic [c_addr_w-1:0]    r_coef_addr;
    logic                   r_alu_en;
    logic [ACC_W-1:0]       r_res_data;
    logic                   r_done;

    // Handshake-facing outputs decode the current state directly
    assign in_ready  = (r_state == LOAD);
    assign res_valid = (r_state == EMIT);
    assign busy      = (r_state != IDLE);

    assign w_load_hs = in_ready  & in_valid;
    assign w_res_hs  = res_valid & res_ready;

    // Lane sums are only meaningful on the final MAC step of a row
    assign w_capture = (r_state == MAC) && (r_k == c_last_k);

    assign w_mu[0] = mu1;
    assign w_mu[1] = mu2;
    assign w_mu[2] = mu3;
    assign w_mu[3] = mu4;

    assign coef_addr = r_coef_addr;
    assign alu_en    = r_alu_en;
    assign x_col0    = r_x_row[0*DATA_W +: DATA_W];
    assign x_col1    = r_x_row[1*DATA_W +: DATA_W];
    assign x_col2    = r_x_row[2*DATA_W +: DATA_W];
    assign x_col3    = r_x_row[3*DATA_W +: DATA_W];
    assign res_data  = r_res_data;
    assign done      = r_done;

    x_buffer u_x_buffer (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (w_load_hs),
        .wr_idx  (r_idx),
        .wr_data (in_data),
        .rd_row  (w_k_nxt),
        .rd_data (w_x_row)
    );

    // State and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_row   <= '0;
            r_k     <= '0;
            r_j     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_row   <= w_row_nxt;
            r_k     <= w_k_nxt;
            r_j     <= w_j_nxt;
        end
    end

    // Next-state and counter logic
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_row_nxt   = r_row;
        w_k_nxt     = r_k;
        w_j_nxt     = r_j;
        w_done_nxt  = 1'b0;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = LOAD;
                    w_idx_nxt   = '0;
                    w_row_nxt   = '0;
                    w_k_nxt     = '0;
                    w_j_nxt     = '0;
                end
            end

            LOAD: begin
                if (w_load_hs) begin
                    w_idx_nxt = r_idx + IDX_W'(1);
                    if (r_idx == c_last_idx) begin
                        w_state_nxt = PRIME;
                    end
                end
            end

            PRIME: begin
                w_state_nxt = MAC;
                w_k_nxt     = '0;
            end

            MAC: begin
                w_k_nxt = r_k + K_W'(1);
                if (r_k == c_last_k) begin
                    w_state_nxt = EMIT;
                    w_j_nxt     = '0;
                end
            end

            EMIT: begin
                if (w_res_hs) begin
                    w_j_nxt = r_j + COL_W'(1);
                    if (r_j == c_last_col) begin
                        if (r_row == c_last_row) begin
                            w_state_nxt = IDLE;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_row_nxt   = r_row + c_row_w'(1);
                            w_state_nxt = PRIME;
                        end
                    end
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Result source: on the capture cycle the fresh ALU sums bypass the
    // result registers so the first result can be registered into res_data
    always_comb begin
        for (int c = 0; c < COLS; c++) begin
            w_res_src[c] = w_capture ? w_mu[c] : r_result[c];
        end
    end

    // Row result registers, loaded once per row on the last MAC step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < COLS; c++) begin
                r_result[c] <= '0;
            end
        end else if (w_capture) begin
            for (int c = 0; c < COLS; c++) begin
                r_result[c] <= w_mu[c];
            end
        end
    end

    // Registered outputs are computed from the next state so that they are
    // aligned with the state they belong to: the ROM address leads alu_en by
    // one cycle (PRIME presents k=0, MAC step k presents k+1)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_coef_addr <= '0;
            r_alu_en    <= 1'b0;
            r_x_row     <= '0;
            r_res_data  <= '0;
            r_done      <= 1'b0;
        end else begin
            r_alu_en <= (w_state_nxt == MAC);
            r_done   <= w_done_nxt;
            r_x_row  <= (w_state_nxt == MAC) ? w_x_row : '0;

            if (w_state_nxt == PRIME) begin
                r_coef_addr <= {w_row_nxt, {K_W{1'b0}}};
            end else if (w_state_nxt == MAC) begin
                // Prefetch wraps on the last step; that address is unused
                r_coef_addr <= {w_row_nxt, w_k_nxt + K_W'(1)};
            end

            // Holding the selected index under backpressure keeps data stable
            if (w_state_nxt == EMIT) begin
                r_res_data <= w_res_src[w_j_nxt];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_matrix_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_matrix_ctrl
// Desc     : Directed self-checking bench for matrix_ctrl with a synchronous
//            coefficient ROM model and a 4-lane accumulate ALU model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_matrix_ctrl;

    localparam int N_ROWS = 4;
    localparam int N_RES  = N_ROWS * 4;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        start     = 1'b0;
    logic        in_valid  = 1'b0;
    logic        res_ready = 1'b0;
    logic [7:0]  in_data   = '0;
    logic        in_ready;
    logic [4:0]  coef_addr;
    logic        alu_en;
    logic [7:0]  x_col0, x_col1, x_col2, x_col3;
    logic [19:0] mu1, mu2, mu3, mu4;
    logic        res_valid;
    logic [19:0] res_data;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    matrix_ctrl #(.N_ROWS(N_ROWS)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .coef_addr (coef_addr),
        .alu_en    (alu_en),
        .x_col0    (x_col0),
        .x_col1    (x_col1),
        .x_col2    (x_col2),
        .x_col3    (x_col3),
        .mu1       (mu1),
        .mu2       (mu2),
        .mu3       (mu3),
        .mu4       (mu4),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .busy      (busy),
        .done      (done)
    );

    // Environment: ROM with one-cycle read latency, accumulators cleared by alu_en low
    logic [7:0]  rom     [32];
    logic [7:0]  xmem    [32];
    logic [19:0] exp_res [N_RES];
    logic [7:0]  rom_q = '0;
    logic [19:0] acc0 = '0, acc1 = '0, acc2 = '0, acc3 = '0;

    always @(posedge clk) begin
        rom_q <= rom[coef_addr];
        acc0  <= alu_en ? mu1 : 20'd0;
        acc1  <= alu_en ? mu2 : 20'd0;
        acc2  <= alu_en ? mu3 : 20'd0;
        acc3  <= alu_en ? mu4 : 20'd0;
    end

    assign mu1 = acc0 + 20'(rom_q) * 20'(x_col0);
    assign mu2 = acc1 + 20'(rom_q) * 20'(x_col1);
    assign mu3 = acc2 + 20'(rom_q) * 20'(x_col2);
    assign mu4 = acc3 + 20'(rom_q) * 20'(x_col3);

    // Monitor: results, alu_en runs, done pulses (sampled on the falling edge)
    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int alu_cnt = 0, alu_run = 0, run_cnt = 0, bad_run = 0, done_cnt = 0, overlap = 0;
    logic [19:0] res_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst_n) begin
            alu_run <= 0;
        end else begin
            if (alu_en) begin
                alu_cnt <= alu_cnt + 1;
                alu_run <= alu_run + 1;
            end else begin
                if (alu_run != 0) begin
                    run_cnt <= run_cnt + 1;
                    if (alu_run != 8) bad_run <= bad_run + 1;
                end
                alu_run <= 0;
            end
            if (done) done_cnt <= done_cnt + 1;
            if (alu_en && res_valid) overlap <= overlap + 1;
            if (res_valid && res_ready) res_q.push_back(res_data);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_in_ready"},  32'(in_ready),  32'd0);
        chk({tag, "_coef_addr"}, 32'(coef_addr), 32'd0);
        chk({tag, "_alu_en"},    32'(alu_en),    32'd0);
        chk({tag, "_x_cols"},    {x_col3, x_col2, x_col1, x_col0}, 32'd0);
        chk({tag, "_res_valid"}, 32'(res_valid), 32'd0);
        chk({tag, "_res_data"},  32'(res_data),  32'd0);
        chk({tag, "_busy"},      32'(busy),      32'd0);
        chk({tag, "_done"},      32'(done),      32'd0);
    endtask

    // Stimulus tables with hand-derived expected results
    function automatic void set_ones();
        for (int i = 0; i < 32; i++) xmem[i] = 8'd1;
        for (int r = 0; r < N_ROWS; r++)
            for (int k = 0; k < 8; k++) rom[r*8+k] = 8'(r + 1);
        for (int r = 0; r < N_ROWS; r++)
            for (int c = 0; c < 4; c++) exp_res[r*4+c] = 20'(8 * (r + 1));
    endfunction

    function automatic void set_max();
        for (int i = 0; i < 32; i++) begin
            xmem[i] = 8'd255;
            rom[i]  = 8'd255;
        end
        for (int i = 0; i < N_RES; i++) exp_res[i] = 20'h7F008;
    endfunction

    // X[k][c] = 4k+c; row r weights only step k=2r+1 by 2 -> 2*(4*(2r+1)+c)
    function automatic void set_onehot();
        for (int i = 0; i < 32; i++) xmem[i] = 8'(i);
        for (int r = 0; r < N_ROWS; r++)
            for (int k = 0; k < 8; k++) rom[r*8+k] = (k == 2*r+1) ? 8'd2 : 8'd0;
        for (int r = 0; r < N_ROWS; r++)
            for (int c = 0; c < 4; c++) exp_res[r*4+c] = 20'(2 * (4*(2*r+1) + c));
    endfunction

    task automatic load_x(input bit gaps, input bit glitch, output int bad);
        int g;
        bad = 0;
        for (int i = 0; i < 32; i++) begin
            if (gaps) begin
                g = int'($urandom_range(0, 2));
                for (int q = 0; q < g; q++) begin
                    in_valid = 1'b0;
                    start    = 1'b0;
                    @(negedge clk);
                    if (!in_ready) bad++;
                    tick();
                end
            end
            in_valid = 1'b1;
            in_data  = xmem[i];
            start    = glitch && (i == 10);
            @(negedge clk);
            if (!in_ready) bad++;
            tick();
        end
        in_valid = 1'b0;
        start    = 1'b0;
        in_data  = '0;
    endtask

    task automatic do_job(input string tag, input bit gaps, input bit bp, input bit glitch);
        int base, alu0, run0, bad0, done0, ovl0, bad_ld, t0, t1, n, hs;
        bit seen;
        logic [19:0] held;
        base  = res_q.size();
        alu0  = alu_cnt;
        run0  = run_cnt;
        bad0  = bad_run;
        done0 = done_cnt;
        ovl0  = overlap;
        held  = '0;

        start = 1'b1;
        tick();
        start = 1'b0;
        load_x(gaps, glitch, bad_ld);
        t0 = cyc;
        chk({tag, "_load_ready"}, bad_ld, 0);

        // First cycle after the 32nd beat must be PRIME for row 0
        @(negedge clk);
        chk({tag, "_prime_in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_prime_alu_en"},   32'(alu_en),   32'd0);
        chk({tag, "_prime_addr"},     32'(coef_addr), 32'd0);
        chk({tag, "_prime_busy"},     32'(busy),     32'd1);

        if (glitch) begin
            tick();
            start = 1'b1;
            tick();
            start = 1'b0;
        end

        if (bp) begin
            hs = 0;
            n  = 0;
            while (hs < 6 && n < 300) begin
                @(negedge clk);
                if (res_valid && res_ready) hs++;
                n++;
            end
            chk({tag, "_bp_reach"}, hs, 6);
            tick();
            res_ready = 1'b0;
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                if (i == 0) held = res_data;
                else chk($sformatf("%s_bp_hold%0d", tag, i), 32'(res_data), 32'(held));
                chk($sformatf("%s_bp_valid%0d", tag, i), 32'(res_valid), 32'd1);
                chk($sformatf("%s_bp_alu%0d", tag, i),   32'(alu_en),    32'd0);
                tick();
            end
            chk({tag, "_bp_value"}, 32'(held), 32'(exp_res[6]));
            res_ready = 1'b1;
        end

        seen = 1'b0;
        n    = 0;
        while (!seen && n < 400) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            n++;
        end
        t1 = cyc;
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
        chk({tag, "_latency"}, t1 - t0, 13 * N_ROWS + (bp ? 5 : 0));
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
        tick();
        @(negedge clk);
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        tick();
        tick();

        chk({tag, "_done_count"}, done_cnt - done0, 1);
        chk({tag, "_alu_cycles"}, alu_cnt - alu0, 8 * N_ROWS);
        chk({tag, "_alu_runs"},   run_cnt - run0, N_ROWS);
        chk({tag, "_alu_badrun"}, bad_run - bad0, 0);
        chk({tag, "_alu_in_emit"}, overlap - ovl0, 0);
        chk({tag, "_res_count"}, res_q.size() - base, N_RES);
        for (int i = 0; i < N_RES; i++) begin
            chk($sformatf("%s_res%0d", tag, i),
                (base + i < res_q.size()) ? 32'(res_q[base+i]) : 32'hFFFFF,
                32'(exp_res[i]));
        end
    endtask

    task automatic reset_mid_mac();
        int bad_ld, n;
        bit found;
        start = 1'b1;
        tick();
        start = 1'b0;
        load_x(1'b0, 1'b0, bad_ld);
        found = 1'b0;
        n     = 0;
        // Row 2, step 4 presents prefetch address 2*8+5
        while (!found && n < 200) begin
            @(negedge clk);
            if (alu_en && coef_addr == 5'd21) found = 1'b1;
            n++;
        end
        chk("mac_rst_reach", 32'(found), 32'd1);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("mac_rst_async");
        tick();
        tick();
        @(negedge clk);
        check_idle_outputs("mac_rst_held");
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        set_ones();
        rst_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            start     = 1'($urandom_range(0, 1));
            in_valid  = 1'($urandom_range(0, 1));
            res_ready = 1'($urandom_range(0, 1));
            in_data   = 8'($urandom);
            tick();
        end
        @(negedge clk);
        check_idle_outputs("rst_hold");
        start     = 1'b0;
        in_valid  = 1'b0;
        res_ready = 1'b1;
        in_data   = '0;
        rst_n     = 1'b1;
        repeat (4) tick();
        @(negedge clk);
        check_idle_outputs("idle_after_rst");
        tick();

        set_ones();
        do_job("ones", 1'b0, 1'b0, 1'b1);
        set_max();
        do_job("max", 1'b0, 1'b0, 1'b0);
        set_onehot();
        do_job("onehot", 1'b1, 1'b1, 1'b1);
        set_ones();
        reset_mid_mac();
        set_ones();
        do_job("ones_after_rst", 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/matrix_ctrl.md
# matrix_ctrl

Sequencer for the 4-lane multiply-accumulate ALU. It buffers an 8x4 input matrix X streamed in over a valid/ready port, then computes one output row at a time. For each row it steps the coefficient ROM address, drives ALU enable and the four X operands for 8 MAC cycles, and captures the four 20-bit sums. It streams each row's four results out over a valid/ready port. It sits between the input loader, the coefficient ROM, the ALU and the result writer.

## Interface
- N_ROWS, 4: number of coefficient rows (output rows) per job; power of two, ≥2.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  job request; sampled only in IDLE.
- in_valid  in  1  X byte valid.
- in_ready  out  1  X byte accepted when in_valid & in_ready.
- in_data  in  8  X element, row-major order: k=0..7, col=0..3, index = k*4+col.
- coef_addr  out  $clog2(N_ROWS)+3  synchronous coefficient ROM address = r*8+k; data returns next cycle.
- alu_en  out  1  ALU enable; low clears the ALU accumulators.
- x_col0..x_col3  out  8 each  X[k][0..3] for the current MAC step.
- mu1..mu4  in  20 each  ALU combinational sums.
- res_valid  out  1  result valid.
- res_ready  in  1  result accepted when res_valid & res_ready.
- res_data  out  20  result, order per row: col 0,1,2,3.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse at job completion.

## Operation
- States: IDLE, LOAD, PRIME, MAC, EMIT.
- IDLE: start=1 → LOAD, clear load index and row r. start in any other state is ignored.
- LOAD: in_ready=1. Each handshake writes in_data to X[idx], then idx++. Gaps in in_valid are allowed. The handshake at idx=31 → PRIME.
- PRIME: coef_addr=r*8+0, alu_en=0. Always one cycle, then → MAC with k=0.
- MAC: alu_en=1, x_colN=X[k][N], coef_addr=r*8+k+1 (prefetch; value at k=7 is don't-care). k++ each cycle.
  - At k=7, capture mu1..mu4 into four result registers → EMIT.
- EMIT: alu_en=0, which clears the ALU. res_valid=1 and res_data=result[j].
  - Each handshake advances j.
  - Handshake at j=3: if r=N_ROWS-1 → IDLE and pulse done; else r++ → PRIME.
- Arithmetic: unsigned. Max sum is 8·255·255 = 520200 < 2^20, so no overflow and no saturation.
- X contents persist after the job; a new start always reloads all 32 bytes.
- Reset (any state, including mid-MAC or mid-EMIT): immediately → IDLE. All outputs 0, indices 0, X buffer 0.

## Timing
- All outputs registered except in_ready, res_valid and busy, which decode state.
- Reset values: in_ready 0, coef_addr 0, alu_en 0, x_col0..3 0, res_valid 0, res_data 0, busy 0, done 0.
- ROM read latency is exactly 1 cycle. The address for step k is presented one cycle before alu_en is asserted for step k.
- alu_en is high for exactly 8 consecutive cycles per row and is never high in PRIME or EMIT.
- Each row has ≥1 alu_en-low cycle before the next row's MAC cycles.
- mu1..mu4 are sampled only in the MAC k=7 cycle.
- Per-row latency with res_ready held high: 1 PRIME + 8 MAC + 4 EMIT = 13 cycles.
- Job latency: 32 load handshakes + 13·N_ROWS cycles.
- done is asserted the cycle after the final result handshake.
- Under backpressure: res_data and res_valid hold stable and the state remains EMIT.

## Structure
- Package matrix_pkg: K=8, COLS=4, DATA_W=8, ACC_W=20, the state enum, and coef_addr width derivation.
- Sub-module x_buffer: a 32x8 register file with one write port (linear index) and one 4-wide read port (row k → 4 bytes). It has asynchronous active-low reset.
- Top-level FSM, counters and result registers live in matrix_ctrl.

## Test plan
- Reset: hold rst=0 with random inputs → all outputs 0 and busy=0. Release, then idle with start=0 → no change.
- Ones: X all 1, ROM row r all r+1 → results 8,8,8,8 / 16×4 / 24×4 / 32×4 in order. done pulses once. alu_en high exactly 32 cycles total.
- Max: X all 255, all coefficients 255 → every result 520200 (0x7F008).
- Backpressure: drop res_ready for 5 cycles mid-EMIT → res_data stable, alu_en stays 0, and no result is lost or duplicated.
- Handshake edges: start pulses while busy are ignored. Random in_valid gaps during LOAD → PRIME only after the 32nd handshake. X[k][c]=k*4+c with a ROM one-hot column per row gives the exact expected values.
- Reset mid-MAC (row 2, k=4) → next cycle IDLE with outputs 0. A fresh job then completes with correct results.
